// File: rtl/rename_regfile_pkg.sv
// rtl/rename_regfile_pkg.sv - shared defaults, TAG_NONE helper and flat-vector slice macro
`ifndef RRF_SLICE
`define RRF_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package rename_regfile_pkg;
  localparam int unsigned DEF_NREG  = 32;
  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_TAG_W = 5;
  localparam int unsigned DEF_NRD   = 2;

  // All-ones tag of width w (w <= 32); callers cast to their own TAG_W.
  function automatic logic [31:0] tag_none(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction
endpackage

// File: rtl/rename_regfile_rdport.sv
// rtl/rename_regfile_rdport.sv - one combinational read port with optional commit forward
// Forwarding is compiled in when RENAME_REGFILE_BYPASS_EN is defined.
module rename_regfile_rdport
  import rename_regfile_pkg::*;
#(
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned AW    = $clog2(NREG)
) (
  input  logic [AW-1:0]                rs_i,
  input  logic [NREG-1:0][XLEN-1:0]    val_q_i,
  input  logic [NREG-1:0][TAG_W-1:0]   tag_q_i,
  input  logic                         commit_i,
  input  logic [AW-1:0]                commit_rd_i,
  input  logic [XLEN-1:0]              commit_val_i,
  input  logic [TAG_W-1:0]             commit_tag_i,
  output logic [XLEN-1:0]              val_o,
  output logic [TAG_W-1:0]             tag_o,
  output logic                         busy_o
);
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(tag_none(TAG_W));

  always_comb begin
    val_o = '0;
    tag_o = TAG_NONE;
    if (rs_i != '0) begin
      val_o = val_q_i[rs_i];
      tag_o = tag_q_i[rs_i];
`ifdef RENAME_REGFILE_BYPASS_EN
      if (commit_i && (rs_i == commit_rd_i)) begin
        val_o = commit_val_i;
        if (tag_q_i[rs_i] == commit_tag_i) tag_o = TAG_NONE;
      end
`endif
    end
  end

`ifndef RENAME_REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{commit_i, commit_rd_i, commit_val_i, commit_tag_i};
`endif

  assign busy_o = (tag_o != TAG_NONE);
endmodule

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with rename tags, flush and pending counter
// Optional zero-cycle commit forward on reads: RENAME_REGFILE_BYPASS_EN.
`ifndef RRF_SLICE
`define RRF_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned NRD   = DEF_NRD,
  parameter int unsigned AW    = $clog2(NREG)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  issue,
  input  logic [AW-1:0]         issue_rd,
  input  logic [TAG_W-1:0]      issue_tag,
  input  logic                  commit,
  input  logic [AW-1:0]         commit_rd,
  input  logic [XLEN-1:0]       commit_val,
  input  logic [TAG_W-1:0]      commit_tag,
  input  logic                  flush,
  input  logic [NRD*AW-1:0]     rs_flat,
  output logic [NRD*XLEN-1:0]   val_flat,
  output logic [NRD*TAG_W-1:0]  tag_flat,
  output logic [NRD-1:0]        busy_flat,
  output logic [AW:0]           pending_cnt
);
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(tag_none(TAG_W));

  logic [NREG-1:0][XLEN-1:0]  val_q, val_d;
  logic [NREG-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [AW:0]                cnt_q, cnt_d;
  logic                       issue_hit, commit_hit, commit_clr, cnt_inc, cnt_dec;

  always_comb begin
    val_d      = val_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    issue_hit  = issue && (issue_rd != '0);
    commit_hit = commit && (commit_rd != '0);
    commit_clr = commit_hit && (tag_q[commit_rd] == commit_tag) && (tag_q[commit_rd] != TAG_NONE);
    // A same-register issue keeps the entry busy, so neither edge of the count moves.
    cnt_inc    = issue_hit && (tag_q[issue_rd] == TAG_NONE);
    cnt_dec    = commit_clr && !(issue_hit && (issue_rd == commit_rd));

    if (commit_hit) val_d[commit_rd] = commit_val;
    if (commit_clr) tag_d[commit_rd] = TAG_NONE;

    if (flush) begin
      for (int r = 0; r < int'(NREG); r++) tag_d[r] = TAG_NONE;
      cnt_d = '0;
    end else begin
      if (issue_hit) tag_d[issue_rd] = issue_tag;
      cnt_d = cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      val_q <= '0;
      for (int r = 0; r < int'(NREG); r++) tag_q[r] <= TAG_NONE;
      cnt_q <= '0;
    end else if (rdy_in) begin
      val_q <= val_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    rename_regfile_rdport #(
      .NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W), .AW(AW)
    ) u_rdport (
      .rs_i         (`RRF_SLICE(rs_flat, k, AW)),
      .val_q_i      (val_q),
      .tag_q_i      (tag_q),
      .commit_i     (commit && rdy_in),
      .commit_rd_i  (commit_rd),
      .commit_val_i (commit_val),
      .commit_tag_i (commit_tag),
      .val_o        (`RRF_SLICE(val_flat, k, XLEN)),
      .tag_o        (`RRF_SLICE(tag_flat, k, TAG_W)),
      .busy_o       (busy_flat[k])
    );
  end
endmodule

// File: tb/tb_rename_regfile.sv
// tb/tb_rename_regfile.sv - scoreboard bench for rename_regfile
module tb_rename_regfile;
  localparam int NREG = 32, XLEN = 32, TAG_W = 5, NRD = 3, AW = 5;
  localparam logic [4:0] NONE = 5'd31;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  logic issue = 1'b0, commit = 1'b0, flush = 1'b0;
  logic [AW-1:0] issue_rd = '0, commit_rd = '0;
  logic [TAG_W-1:0] issue_tag = '0, commit_tag = '0;
  logic [XLEN-1:0] commit_val = '0;
  logic [NRD*AW-1:0] rs_flat = '0;
  logic [NRD*XLEN-1:0] val_flat;
  logic [NRD*TAG_W-1:0] tag_flat;
  logic [NRD-1:0] busy_flat;
  logic [AW:0] pending_cnt;

  rename_regfile #(.NREG(NREG), .XLEN(XLEN), .TAG_W(TAG_W), .NRD(NRD)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .issue(issue), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val), .commit_tag(commit_tag),
    .flush(flush), .rs_flat(rs_flat), .val_flat(val_flat), .tag_flat(tag_flat),
    .busy_flat(busy_flat), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_cnt;
    logic [1:0]  port;
    logic [31:0] val;
    logic [4:0]  tag;
    logic        busy;
    logic [5:0]  cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0, n_bad = 0;

  task automatic exp_rd(input int p, input logic [4:0] r, input logic [31:0] v,
                        input logic [4:0] t, input logic b, input string nm);
    exp_t e;
    rs_flat[p*AW +: AW] = r;
    e = '{is_cnt: 1'b0, port: 2'(p), val: v, tag: t, busy: b, cnt: 6'd0};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic exp_cnt(input logic [5:0] c, input string nm);
    exp_t e;
    e = '{is_cnt: 1'b1, port: 2'd0, val: 32'd0, tag: 5'd0, busy: 1'b0, cnt: c};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    issue = 1'b0; commit = 1'b0; flush = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] r, input logic [4:0] t);
    issue = 1'b1; issue_rd = r; issue_tag = t;
  endtask

  task automatic do_commit(input logic [4:0] r, input logic [31:0] v, input logic [4:0] t);
    commit = 1'b1; commit_rd = r; commit_val = v; commit_tag = t;
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    logic [31:0] av;
    logic [4:0]  at;
    logic        ab;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if (e.is_cnt) begin
          if (pending_cnt !== e.cnt) begin
            n_bad++;
            $display("FAIL %s: pending_cnt=%0d expected %0d", nm, pending_cnt, e.cnt);
          end
        end else begin
          av = val_flat[int'(e.port)*XLEN +: XLEN];
          at = tag_flat[int'(e.port)*TAG_W +: TAG_W];
          ab = busy_flat[e.port];
          if (av !== e.val || at !== e.tag || ab !== e.busy) begin
            n_bad++;
            $display("FAIL %s: port%0d val=%h tag=%0d busy=%b expected val=%h tag=%0d busy=%b",
                     nm, e.port, av, at, ab, e.val, e.tag, e.busy);
          end
        end
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    exp_rd(0, 5'd5, 32'd0, NONE, 1'b0, "reset_r5");
    exp_rd(1, 5'd0, 32'd0, NONE, 1'b0, "reset_r0");
    exp_cnt(6'd0, "reset_cnt");
    rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-run, checked before any further clock edge
    do_issue(5'd5, 5'd3); tick();
    exp_rd(0, 5'd5, 32'd0, 5'd3, 1'b1, "issue_r5");
    exp_cnt(6'd1, "issue_cnt");
    tick();
    rst_n = 1'b0;
    exp_rd(0, 5'd5, 32'd0, NONE, 1'b0, "async_rst_r5");
    exp_cnt(6'd0, "async_rst_cnt");
    tick();
    rst_n = 1'b1;

    do_issue(5'd5, 5'd3); tick();
    do_commit(5'd5, 32'hDEAD, 5'd3); tick();
    exp_rd(0, 5'd5, 32'hDEAD, NONE, 1'b0, "commit_r5");
    exp_cnt(6'd0, "commit_cnt");

    // Stale commit must not clear the newer rename
    do_issue(5'd7, 5'd2); tick();
    do_issue(5'd7, 5'd4); tick();
    exp_cnt(6'd1, "rerename_cnt");
    do_commit(5'd7, 32'h11, 5'd2); tick();
    exp_rd(0, 5'd7, 32'h11, 5'd4, 1'b1, "stale_commit_r7");
    exp_cnt(6'd1, "stale_commit_cnt");

    do_issue(5'd9, 5'd1); tick();
    exp_cnt(6'd2, "issue_r9_cnt");
    do_issue(5'd9, 5'd6); do_commit(5'd9, 32'h55, 5'd1); tick();
    exp_rd(1, 5'd9, 32'h55, 5'd6, 1'b1, "same_cycle_r9");
    exp_cnt(6'd2, "same_cycle_cnt");

    do_issue(5'd2, 5'd9); tick();
    exp_cnt(6'd3, "issue_r2_cnt");
    flush = 1'b1; do_issue(5'd3, 5'd8); do_commit(5'd2, 32'h77, 5'd9); tick();
    exp_rd(0, 5'd2, 32'h77, NONE, 1'b0, "flush_r2");
    exp_rd(1, 5'd3, 32'd0, NONE, 1'b0, "flush_r3");
    exp_rd(2, 5'd7, 32'h11, NONE, 1'b0, "flush_r7");
    exp_cnt(6'd0, "flush_cnt");
    tick();
    exp_rd(2, 5'd9, 32'h55, NONE, 1'b0, "flush_r9");

    // Commit-to-read forward, visible on every port in the commit cycle
    do_issue(5'd4, 5'd10); tick();
    do_commit(5'd4, 32'hBEEF, 5'd10);
    for (int p = 0; p < NRD; p++) begin
`ifdef RENAME_REGFILE_BYPASS_EN
      exp_rd(p, 5'd4, 32'hBEEF, NONE, 1'b0, "bypass_r4");
`else
      exp_rd(p, 5'd4, 32'd0, 5'd10, 1'b1, "nobypass_r4");
`endif
    end
    tick();
    for (int p = 0; p < NRD; p++) exp_rd(p, 5'd4, 32'hBEEF, NONE, 1'b0, "after_commit_r4");
    exp_cnt(6'd0, "after_commit_cnt");

    do_issue(5'd0, 5'd5); do_commit(5'd0, 32'h123, 5'd5); tick();
    exp_rd(0, 5'd0, 32'd0, NONE, 1'b0, "r0_ignored");
    exp_cnt(6'd0, "r0_cnt");

    do_issue(5'd6, 5'd7); tick();
    rdy = 1'b0;
    do_commit(5'd6, 32'h99, 5'd7); do_issue(5'd8, 5'd1); flush = 1'b1; tick();
    exp_rd(0, 5'd6, 32'd0, 5'd7, 1'b1, "frozen_r6");
    exp_rd(1, 5'd8, 32'd0, NONE, 1'b0, "frozen_r8");
    exp_cnt(6'd1, "frozen_cnt");
    tick();
    rdy = 1'b1;
    do_commit(5'd6, 32'h99, 5'd7); tick();
    exp_rd(0, 5'd6, 32'h99, NONE, 1'b0, "unfrozen_r6");
    exp_cnt(6'd0, "unfrozen_cnt");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with rename-tag table for the Tomasulo core.
- Sits between the decoder/dispatch (issue-time rename and operand read) and the ROB (in-order commit writeback, mispredict flush).
- Generalises the existing single-config file:
  - N read ports.
  - Configurable register count, data width and tag width.
  - Global flush.
  - Commit value always updates architectural state.
  - Outstanding-rename counter.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hardwired zero.
- XLEN, 32, data width.
- TAG_W, 5, ROB tag width; all-ones (TAG_NONE) means "not renamed", so the ROB holds at most 2^TAG_W-1 entries.
- NRD, 2, number of read ports.
- AW, $clog2(NREG), register index width (derived; do not override).

Ports:
- clk_in  in  1  clock, posedge.
- rst_n_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- issue  in  1  rename request from dispatch.
- issue_rd  in  AW  destination register.
- issue_tag  in  TAG_W  ROB tag assigned to issue_rd.
- commit  in  1  ROB commit strobe.
- commit_rd  in  AW  committed destination.
- commit_val  in  XLEN  committed value.
- commit_tag  in  TAG_W  ROB tag of the committing entry.
- flush  in  1  mispredict: discard all renames.
- rs_flat  in  NRD*AW  read indices; port k uses slice k.
- val_flat  out  NRD*XLEN  read values.
- tag_flat  out  NRD*TAG_W  read rename tags.
- busy_flat  out  NRD  1 when tag != TAG_NONE.
- pending_cnt  out  AW+1  number of registers currently renamed.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - All val=0 and all tag=TAG_NONE.
  - pending_cnt=0.
  - Read outputs therefore give 0/TAG_NONE/0.
- State updates happen only on posedge with rdy_in=1. With rdy_in=0, issue, commit and flush are ignored, and reads still reflect the stored state.
- Register 0: never written, never renamed; reads always return 0/TAG_NONE/0.
- Commit (commit=1, commit_rd!=0):
  - val[commit_rd] <= commit_val unconditionally; commits are in order.
  - tag[commit_rd] <= TAG_NONE only if tag[commit_rd]==commit_tag.
- Issue (issue=1, issue_rd!=0): tag[issue_rd] <= issue_tag.
- Same cycle, same register, issue and commit: the value is written and the issue tag wins.
- Flush: all tags become TAG_NONE next cycle.
  - Flush dominates a same-cycle issue; that issue is dropped.
  - A same-cycle commit still writes its value.
- Reads are combinational:
  - Port k returns the stored val/tag for rs k.
  - Reads never see a same-cycle issue, so an instruction reads its sources before its own rename.
- pending_cnt:
  - Tracks the count of non-NONE tags, registered.
  - +1 when issue renames a previously free register.
  - -1 when commit clears a matching tag.
  - Net 0 when both apply to the same register, or when an issue re-renames an already busy register.
  - Flush sets it to 0.
  - Never wraps, since it is bounded by NREG-1.

Optional Feature:
- Macro RENAME_REGFILE_BYPASS_EN.
- Defined:
  - A read with rs==commit_rd!=0 and commit=1 returns val=commit_val.
  - It returns tag=TAG_NONE and busy=0 if the stored tag equals commit_tag; otherwise the stored tag.
  - This is a zero-cycle commit-to-dispatch forward.
- Undefined:
  - Reads return the stored state only.
  - Dispatch must tolerate a one-cycle-stale busy bit; the ROB broadcast covers it.

Decomposition:
- Package rename_regfile_pkg:
  - Default XLEN/TAG_W/NREG.
  - TAG_NONE as a function of TAG_W, ({TAG_W{1'b1}}).
  - Slice helper macros for the flat port vectors.
- One sub-module, rename_regfile_rdport:
  - Combinational read-plus-bypass for a single port.
  - Instantiated NRD times in a generate loop.

Test Plan:
- Reset mid-run: issue r5 tag 3, assert rst_n_in low asynchronously -> r5 reads val 0, tag 31, busy 0, pending_cnt 0, with no clock edge needed.
- Issue r5 tag 3, then commit r5 0xDEAD tag 3 -> r5 val 0xDEAD, tag 31, pending_cnt back to 0.
- Stale commit: issue r7 tag 2, issue r7 tag 4, commit r7 0x11 tag 2 -> val 0x11, tag stays 4, busy 1, pending_cnt 1.
- Same cycle: issue r9 tag 6 plus commit r9 0x55 tag 1 (old tag 1) -> val 0x55, tag 6, pending_cnt unchanged.
- Flush with simultaneous issue r3 tag 8 and commit r2 0x77 -> all tags 31, r2=0x77, r3 unrenamed, pending_cnt 0.
- Bypass (macro on), NRD=3:
  - All ports read r4 while commit r4 0xBEEF matches its tag -> all ports give 0xBEEF and busy 0 in the same cycle.
  - Macro off -> old value and busy 1.
  - Writes to r0 are ignored, and rdy_in=0 freezes state.
